// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the PC sequencer.
// FSM state encoding, next-PC select encoding and reset/exception vectors.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_SEQ = 3'd0,
        SEL_BR  = 3'd1,
        SEL_J   = 3'd2,
        SEL_JR  = 3'd3,
        SEL_EXC = 3'd4
    } sel_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0100;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select and target arithmetic.
// Exception requests are honoured only when PC_SEQ_EXC_EN is defined.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic [4:0]  pc_hi_i,
    input  logic [31:0] pc_plus1_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_offset_i,
    input  logic        jump_i,
    input  logic [26:0] jump_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        exc_i,
    output logic        redirect_o,
    output logic [2:0]  sel_o,
    output logic [31:0] target_o
);

    logic exc_req;

`ifdef PC_SEQ_EXC_EN
    assign exc_req = exc_i;
`else
    logic unused_exc;
    assign exc_req    = 1'b0;
    assign unused_exc = exc_i;
`endif

    // Fixed priority: exc > jr > jump > br_taken > sequential.
    always_comb begin
        sel_o    = SEL_SEQ;
        target_o = pc_plus1_i;
        if (exc_req) begin
            sel_o    = SEL_EXC;
            target_o = EXC_VECTOR;
        end else if (jr_i) begin
            sel_o    = SEL_JR;
            target_o = jr_target_i;
        end else if (jump_i) begin
            sel_o    = SEL_J;
            target_o = {pc_hi_i, jump_target_i};
        end else if (br_taken_i) begin
            sel_o    = SEL_BR;
            target_o = pc_plus1_i + {{16{br_offset_i[15]}}, br_offset_i};
        end
    end

    assign redirect_o = (sel_o != SEL_SEQ);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/FETCH/HOLD FSM with branch/jump/exception redirect.
// Exception redirect and the epc register exist only when PC_SEQ_EXC_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jump,
    input  logic [26:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1,
    output logic        fetch_valid,
    output logic [31:0] epc,
    output logic [1:0]  dbg_state
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect;
    logic [2:0]  sel;
    logic [31:0] target;
    logic        epc_load;

    assign pc        = pc_q;
    assign pc_plus1  = pc_q + 32'd1;
    assign dbg_state = state_q;

    pc_next_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .pc_hi_i       (pc_q[31:27]),
        .pc_plus1_i    (pc_plus1),
        .br_taken_i    (br_taken),
        .br_offset_i   (br_offset),
        .jump_i        (jump),
        .jump_target_i (jump_target),
        .jr_i          (jr),
        .jr_target_i   (jr_target),
        .exc_i         (exc),
        .redirect_o    (redirect),
        .sel_o         (sel),
        .target_o      (target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // A redirect squashes any coincident ack and overrides stall; BOOT ignores it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        epc_load    = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d     = target;
                    epc_load = (sel == SEL_EXC);
                end else if (imem_ack) begin
                    fetch_valid = 1'b1;
                    if (stall) begin
                        state_d = HOLD;
                    end else begin
                        pc_d = pc_plus1;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d     = target;
                    state_d  = FETCH;
                    epc_load = (sel == SEL_EXC);
                end else if (!stall) begin
                    pc_d    = pc_plus1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

`ifdef PC_SEQ_EXC_EN
    logic [31:0] epc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q <= 32'd0;
        end else if (epc_load) begin
            epc_q <= pc_q;
        end
    end

    assign epc = epc_q;
`else
    logic unused_epc_load;
    assign unused_epc_load = epc_load;
    assign epc             = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; expected epc/redirect results
// follow PC_SEQ_EXC_EN so the same bench serves both builds.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_offset = '0;
    logic        jump = 1'b0;
    logic [26:0] jump_target = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic        exc = 1'b0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        fetch_valid;
    logic [31:0] epc;
    logic [1:0]  dbg_state;

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jump        (jump),
        .jump_target (jump_target),
        .jr          (jr),
        .jr_target   (jr_target),
        .exc         (exc),
        .imem_ack    (imem_ack),
        .imem_req    (imem_req),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .fetch_valid (fetch_valid),
        .epc         (epc),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: inputs change on the falling edge, outputs settle 1 time unit later
    task automatic drive(input logic s, input logic ack, input logic brt, input logic [15:0] off,
                         input logic j, input logic [26:0] jt, input logic jrr,
                         input logic [31:0] jrt, input logic e);
        @(negedge clk);
        stall = s; imem_ack = ack; br_taken = brt; br_offset = off;
        jump = j; jump_target = jt; jr = jrr; jr_target = jrt; exc = e;
        #1;
    endtask

    task automatic nop(input logic ack);
        drive(1'b0, ack, 1'b0, 16'h0, 1'b0, 27'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic go_jr(input logic [31:0] t);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 27'h0, 1'b1, t, 1'b0);
    endtask

    // monitor: every fetch_valid strobe must match the next expected pc
    always @(negedge clk) begin
        #2;
        if (fetch_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_unexpected: got pc %h expected no fetch_valid", pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (pc !== e) begin
                    n_fail++;
                    $display("FAIL fetch_pc: got %h expected %h", pc, e);
                end
            end
        end
    end

    initial begin
        imem_ack = 1'b1;
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_fv", {31'd0, fetch_valid}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, BOOT);

        // reset release, ack every cycle
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("boot_state", {30'd0, dbg_state}, BOOT);
        check("boot_req", {31'd0, imem_req}, 32'd0);
        check("boot_fv", {31'd0, fetch_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(i));
            nop(1'b1);
            check("seq_fv", {31'd0, fetch_valid}, 32'd1);
            check("seq_req", {31'd0, imem_req}, 32'd1);
        end

        // stall with ack at pc=10
        go_jr(32'd10);
        check("jr_noack_fv", {31'd0, fetch_valid}, 32'd0);
        exp_q.push_back(32'd10);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 27'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 27'h0, 1'b0, 32'h0, 1'b0);
            check("hold_state", {30'd0, dbg_state}, HOLD);
            check("hold_pc", pc, 32'd10);
            check("hold_req", {31'd0, imem_req}, 32'd0);
        end
        nop(1'b0);
        check("hold_release_pc", pc, 32'd10);
        nop(1'b0);
        check("after_hold_pc", pc, 32'd11);
        check("after_hold_state", {30'd0, dbg_state}, FETCH);

        // negative branch squashes coincident ack
        go_jr(32'd20);
        drive(1'b0, 1'b1, 1'b1, 16'hFFFB, 1'b0, 27'h0, 1'b0, 32'h0, 1'b0);
        check("br_squash_fv", {31'd0, fetch_valid}, 32'd0);
        check("br_pc_plus1", pc_plus1, 32'd21);
        drive(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 27'h0, 1'b0, 32'h0, 1'b0);
        check("br_neg_pc", pc, 32'd16);
        drive(1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 27'h0000123, 1'b0, 32'h0, 1'b0);
        check("br_pos_pc", pc, 32'd33);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 27'h0000777, 1'b1, 32'hA000_0005, 1'b0);
        check("jump_over_br_pc", pc, 32'h0000_0123);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 27'h0000123, 1'b0, 32'h0, 1'b0);
        check("jr_over_jump_pc", pc, 32'hA000_0005);
        nop(1'b0);
        check("jump_hi_bits_pc", pc, 32'hA000_0123);

        // exc + jr + br_taken together at pc=40
        go_jr(32'd40);
        drive(1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 27'h0, 1'b1, 32'h1234_5678, 1'b1);
        check("exc_squash_fv", {31'd0, fetch_valid}, 32'd0);
        check("exc_cur_pc", pc, 32'd40);
        nop(1'b0);
`ifdef PC_SEQ_EXC_EN
        check("exc_pc", pc, 32'h0000_0100);
        check("exc_epc", epc, 32'd40);
`else
        check("exc_pc", pc, 32'h1234_5678);
        check("exc_epc", epc, 32'd0);
`endif

        // redirect while in HOLD overrides stall
        go_jr(32'd50);
        exp_q.push_back(32'd50);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 27'h0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 27'h0, 1'b1, 32'd60, 1'b0);
        check("hold_redir_cur_pc", pc, 32'd50);
        nop(1'b0);
        check("hold_redir_pc", pc, 32'd60);
        check("hold_redir_state", {30'd0, dbg_state}, FETCH);

        // wrap at 32'hFFFF_FFFF, then reset mid-HOLD
        go_jr(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFF);
        nop(1'b1);
        check("wrap_pc_plus1", pc_plus1, 32'h0);
        exp_q.push_back(32'h0);
        nop(1'b1);
        check("wrap_pc", pc, 32'h0);
        exp_q.push_back(32'h1);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 27'h0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 27'h0, 1'b0, 32'h0, 1'b0);
        check("pre_rst_state", {30'd0, dbg_state}, HOLD);
        check("pre_rst_pc", pc, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_epc", epc, 32'h0);
        check("async_rst_state", {30'd0, dbg_state}, BOOT);
        check("async_rst_fv", {31'd0, fetch_valid}, 32'd0);
        nop(1'b1);
        nop(1'b1);

        // redirect during BOOT is ignored
        @(negedge clk);
        rst_n = 1'b1; jr = 1'b1; jr_target = 32'd77; imem_ack = 1'b1;
        #1;
        check("boot2_fv", {31'd0, fetch_valid}, 32'd0);
        nop(1'b0);
        check("boot_redir_ignored_pc", pc, 32'h0);
        check("boot2_exit_state", {30'd0, dbg_state}, FETCH);

        @(negedge clk);
        #3;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
